// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- sequential RV32M multiply/divide unit (radix-2, one bit per cycle)
//
// Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on XLEN-bit operands.
// Signed operands are first reduced to magnitudes. An unsigned shift-add
// multiplier or a restoring divider then runs on a 2*XLEN-bit accumulator.
// The sign is corrected on the edge after the last bit, when the result is
// registered.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   request; accepted when in_valid && in_ready && !flush
//   in_ready   unit idle and able to accept
//   op         funct3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (000..111)
//   rs1, rs2   operands, sampled only at accept
//   flush      synchronous abort of any in-flight or completed operation
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   result     operation result, stable while out_valid is high
//   busy       operation in flight or result waiting
//
// Build option
//   MDU_FAST_MUL_EN  multiplies use a combinational 2*XLEN multiplier and
//                    complete one edge after accept. Divides are unchanged.
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic [2*XLEN-1:0] acc;     // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   b_reg;   // multiplier / divisor magnitude
    logic [CW-1:0]     cnt;     // bits still to process
    logic [1:0]        op_r;    // op[1:0] is enough once the engine is chosen
    logic              neg_q;   // product / quotient must be negated
    logic              neg_r;   // remainder must be negated (dividend sign)
    logic              short_r; // result already loaded at accept

    // ---------------- accept-time decode ----------------
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, special, short_op, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign is_div   = op[2];
    assign a_signed = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg    = a_signed & rs1[XLEN-1];
    assign b_neg    = b_signed & rs2[XLEN-1];
    assign a_mag    = a_neg ? -rs1 : rs1;
    assign b_mag    = b_neg ? -rs2 : rs2;

    assign div_zero = is_div && (rs2 == '0);
    assign div_ovf  = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign special  = div_zero || div_ovf;
    // op[1] selects REM/REMU over DIV/DIVU
    assign special_res = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

    assign accept = in_valid && in_ready && !flush;

    // Sign-correct a 2*XLEN magnitude product and pick the low half (MUL) or high half.
    function automatic logic [XLEN-1:0] mul_select(input logic [1:0] o, input logic n,
                                                   input logic [2*XLEN-1:0] p);
        logic [2*XLEN-1:0] s;
        s = n ? -p : p;
        return (o == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign short_op  = special || !is_div;
`else
    assign short_op  = special;
`endif

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN-1:0]   quo_mag, rem_mag, div_res;

    // Shift-add: add the multiplier into the high half when the low bit is set,
    // then shift the whole accumulator right, carry included.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide: trial-subtract from the partial remainder shifted left by
    // one. A set top bit means the subtraction underflowed, so keep the shifted
    // value and record a 0 quotient bit.
    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_reg};
    assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign quo_mag = acc[XLEN-1:0];
    assign rem_mag = acc[2*XLEN-1:XLEN];
    assign div_res = op_r[1] ? (neg_r ? -rem_mag : rem_mag)
                             : (neg_q ? -quo_mag : quo_mag);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // Short ops (divide special cases, fast multiplies) spend one cycle in S_DIV
    // with an empty count. Every op therefore reaches DONE one edge after its
    // last work edge.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; a missing branch would infer a latch.
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (accept) state_nxt = (!is_div && !short_op) ? S_MUL : S_DIV;
                S_MUL,
                S_DIV:  if (cnt == '0) state_nxt = S_DONE;
                S_DONE: if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
        if (!rst) begin
            acc     <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            op_r    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            short_r <= 1'b0;
            result  <= '0;
        end else if (!flush) begin
            unique case (state)
                S_IDLE: if (accept) begin
                    op_r    <= op[1:0];
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    b_reg   <= b_mag;
                    acc     <= {{XLEN{1'b0}}, a_mag};
                    short_r <= short_op;
                    cnt     <= short_op ? '0 : CW'(XLEN);
                    if (special) result <= special_res;
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) result <= mul_select(op[1:0], a_neg ^ b_neg, fast_prod);
`endif
                end
                S_MUL: begin
                    if (cnt != '0) begin
                        acc <= mul_next;
                        cnt <= cnt - CW'(1);
                    end else begin
                        result <= mul_select(op_r, neg_q, acc);
                    end
                end
                S_DIV: begin
                    if (cnt != '0) begin
                        acc <= div_next;
                        cnt <= cnt - CW'(1);
                    end else if (!short_r) begin
                        result <= div_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
